// File: rtl/row_sched64_if.sv
// row_sched64_if
// ---------------------------------------------------------------------------
// Groups the handshakes between the row scheduler and its surroundings.
//
// Load stream and SRAM write port:
//   ld_valid    input stream word available (driven by the stream source)
//   ld_ready    scheduler accepts a word; transfer = ld_valid & ld_ready
//   sram_wen    input SRAM write enable (one per accepted word)
//   sram_waddr  input SRAM write address (word index within the row)
//   sram_bank   ping-pong bank being written
//
// MAC-array compute handshake:
//   cmp_start   one-cycle pulse starting compute of one row
//   cmp_bank    bank the MAC array reads for the row in compute
//   cmp_done    MAC array finished the current row
//
// Modports: master = scheduler side, slave = stream source / MAC array side.
// ---------------------------------------------------------------------------
interface row_sched64_if #(
  parameter int WORD_BITS = 10
);

  logic                 ld_valid;
  logic                 ld_ready;
  logic                 sram_wen;
  logic [WORD_BITS-1:0] sram_waddr;
  logic                 sram_bank;
  logic                 cmp_start;
  logic                 cmp_bank;
  logic                 cmp_done;

  modport master (
    input  ld_valid,
    input  cmp_done,
    output ld_ready,
    output sram_wen,
    output sram_waddr,
    output sram_bank,
    output cmp_start,
    output cmp_bank
  );

  modport slave (
    output ld_valid,
    output cmp_done,
    input  ld_ready,
    input  sram_wen,
    input  sram_waddr,
    input  sram_bank,
    input  cmp_start,
    input  cmp_bank
  );

endinterface

// File: rtl/row_sched64.sv
// row_sched64
// ---------------------------------------------------------------------------
// Row-level scheduler for the 64-MAC DLA. Walks a layer row by row through
// the master phases (FSLD, LEFT, BASE, RIGHT) and runs a ping-pong input
// SRAM load so that row r+1 is loaded into one bank while row r is computed
// out of the other.
//
// Ports:
//   clk           clock, all state on the rising edge
//   reset         asynchronous, active-low; clears all state and outputs
//   start         one-cycle layer start, only looked at in IDLE
//   cfg_rows      number of output rows in the layer (latched on start)
//   cfg_ld_words  words loaded per row (latched on start)
//   bus           load stream / SRAM write / MAC handshake (master side)
//   curr_state    0 IDLE, 1 LEFT, 2 BASE, 3 RIGHT, 4 SYNC, 5 FIN, 7 FSLD
//   curr_row      row currently in compute (holds after the layer ends)
//   busy          high whenever curr_state != IDLE
//   done          one-cycle layer-complete pulse
// ---------------------------------------------------------------------------
module row_sched64 #(
  parameter int ROW_BITS  = 8,
  parameter int WORD_BITS = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ROW_BITS-1:0]  cfg_rows,
  input  logic [WORD_BITS-1:0] cfg_ld_words,
  row_sched64_if.master        bus,
  output logic [2:0]           curr_state,
  output logic [ROW_BITS-1:0]  curr_row,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEFT  = 3'd1,
    S_BASE  = 3'd2,
    S_RIGHT = 3'd3,
    S_SYNC  = 3'd4,
    S_FIN   = 3'd5,
    S_FSLD  = 3'd7
  } state_t;

  localparam logic [ROW_BITS:0] ROW_ONE_EXT = (ROW_BITS+1)'(1);

  state_t               state_q;
  state_t               state_d;

  logic [ROW_BITS-1:0]  rows_q;
  logic [WORD_BITS-1:0] words_q;

  logic                 ld_active;
  logic                 ld_pend;
  logic                 ld_bank;
  logic [WORD_BITS-1:0] ld_cnt;
  logic                 cmp_start_q;

  logic                 xfer;
  logic                 ld_last;
  logic                 next_loaded;
  logic                 cmp_done_ok;
  logic                 on_last_row;

  logic                 accept_cfg;
  logic                 enter_row;
  logic [ROW_BITS-1:0]  enter_idx;
  state_t               enter_phase;
  logic                 enter_loads;

  // A word moves whenever the stream offers one while a load is open; the
  // word at index cfg_ld_words-1 closes the load.
  assign xfer    = bus.ld_valid & ld_active;
  assign ld_last = xfer && (ld_cnt == words_q - WORD_BITS'(1));

  // The next row's data is usable once no load is pending, or when the
  // closing word lands in this very cycle (that word is written at the edge
  // that also starts the next compute, so the MAC never reads it early).
  assign next_loaded = !ld_pend || ld_last;

  // cmp_done arriving together with our own cmp_start belongs to nothing we
  // started, so it is dropped.
  assign cmp_done_ok = bus.cmp_done && !cmp_start_q;
  assign on_last_row = (curr_row == rows_q - ROW_BITS'(1));

  // Next-state logic. enter_row marks the transition into the compute phase
  // of row enter_idx; the phase, the cmp_start pulse and the prefetch of the
  // following row are all derived from that one event.
  always_comb begin
    state_d     = state_q;
    accept_cfg  = 1'b0;
    enter_row   = 1'b0;
    enter_idx   = curr_row;
    enter_phase = S_LEFT;
    enter_loads = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_rows == '0 || cfg_ld_words == '0) begin
            state_d = S_FIN;
          end else begin
            state_d    = S_FSLD;
            accept_cfg = 1'b1;
          end
        end
      end
      S_FSLD: begin
        if (ld_last) begin
          enter_row = 1'b1;
          enter_idx = '0;
        end
      end
      S_LEFT, S_BASE, S_RIGHT: begin
        if (cmp_done_ok) begin
          if (on_last_row) begin
            state_d = S_FIN;
          end else if (next_loaded) begin
            enter_row = 1'b1;
            enter_idx = curr_row + ROW_BITS'(1);
          end else begin
            state_d = S_SYNC;
          end
        end
      end
      S_SYNC: begin
        if (next_loaded) begin
          enter_row = 1'b1;
          enter_idx = curr_row + ROW_BITS'(1);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Row 0 is LEFT (even when it is also the last row), the last row of a
    // multi-row layer is RIGHT, everything in between is BASE.
    if (enter_row) begin
      if (enter_idx == '0) begin
        enter_phase = S_LEFT;
      end else if (enter_idx == rows_q - ROW_BITS'(1)) begin
        enter_phase = S_RIGHT;
      end else begin
        enter_phase = S_BASE;
      end
      state_d     = enter_phase;
      enter_loads = (({1'b0, enter_idx} + ROW_ONE_EXT) < {1'b0, rows_q});
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: latched config, load engine and row counter. The prefetch
  // launch is written after the transfer bookkeeping so that, when the
  // closing word of one load and the launch of the next coincide, the new
  // load wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rows_q      <= '0;
      words_q     <= '0;
      curr_row    <= '0;
      ld_active   <= 1'b0;
      ld_pend     <= 1'b0;
      ld_bank     <= 1'b0;
      ld_cnt      <= '0;
      cmp_start_q <= 1'b0;
    end else begin
      cmp_start_q <= enter_row;

      if (accept_cfg) begin
        rows_q    <= cfg_rows;
        words_q   <= cfg_ld_words;
        curr_row  <= '0;
        ld_active <= 1'b1;
        ld_pend   <= 1'b1;
        ld_bank   <= 1'b0;
        ld_cnt    <= '0;
      end

      if (xfer) begin
        if (ld_last) begin
          ld_cnt    <= '0;
          ld_active <= 1'b0;
          ld_pend   <= 1'b0;
        end else begin
          ld_cnt <= ld_cnt + WORD_BITS'(1);
        end
      end

      if (enter_row) begin
        curr_row <= enter_idx;
        if (enter_loads) begin
          ld_active <= 1'b1;
          ld_pend   <= 1'b1;
          ld_bank   <= ~enter_idx[0];
          ld_cnt    <= '0;
        end
      end
    end
  end

  assign bus.ld_ready   = ld_active;
  assign bus.sram_wen   = xfer;
  assign bus.sram_waddr = ld_cnt;
  assign bus.sram_bank  = ld_bank;
  assign bus.cmp_start  = cmp_start_q;
  assign bus.cmp_bank   = curr_row[0];

  assign curr_state = state_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FIN);

endmodule
